// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and IMEM write bus of the instruction-memory loader
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Loader side: consumes the byte stream, drives the IMEM write port
    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    // Source/memory side: offers bytes, observes the IMEM writes
    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles big-endian words from a byte stream into IMEM; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [31:0]       HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [31:0]       word_sr_q, word_sr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   words_q, words_d;
    // Last written address/data, so the bus holds steady between strobes
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              do_start;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_sr_q  <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            words_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_sr_q  <= word_sr_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            words_q    <= words_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Next-state logic and bus outputs
    always_comb begin
        state_d        = state_q;
        word_sr_d      = word_sr_q;
        byte_cnt_d     = byte_cnt_q;
        addr_d         = addr_q;
        err_d          = err_q;
        words_d        = words_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d          = sum_q;
`endif
        do_start       = 1'b0;
        bus.in_ready   = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = wr_addr_q;
        bus.imem_wdata = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                do_start = start;
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    word_sr_d  = {word_sr_q[23:0], bus.in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + bus.in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                bus.imem_we    = 1'b1;
                bus.imem_addr  = addr_q;
                bus.imem_wdata = word_sr_q;
                wr_addr_d      = addr_q;
                wr_data_d      = word_sr_q;
                words_d        = words_q + 1'b1;
                if (word_sr_q == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    // Capacity exhausted without a halt word
                    err_d   = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    // Two's complement of the running sum makes the total wrap to zero
                    if (bus.in_data == (~sum_q + 8'd1)) begin
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FAIL;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A start from a resting state begins a fresh load at address 0
        if (do_start) begin
            state_d    = S_LOAD;
            addr_d     = '0;
            byte_cnt_d = '0;
            err_d      = 1'b0;
            words_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
        end
    end

    // Status outputs decoded from registered state
    always_comb begin
        cpu_run      = (state_q == S_DONE);
        busy         = (state_q == S_LOAD) || (state_q == S_WRITE)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (state_q == S_CHECK)
`endif
                       ;
        err          = err_q;
        words_loaded = words_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            cpu_run;
    logic            busy;
    logic            err;
    logic [ADDR_W:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+31:0] sb_q[$];
    logic [ADDR_W-1:0]  exp_addr;
    logic [7:0]         sum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every IMEM write must match the oldest expected {addr,data}
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            logic [ADDR_W+31:0] exp;
            check("in_ready_in_write", {63'd0, bus.in_ready}, 64'd0);
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none", bus.imem_addr);
            end
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check("write_addr", 64'(bus.imem_addr), 64'(exp[ADDR_W+31:32]));
                check("write_data", 64'(bus.imem_wdata), 64'(exp[31:0]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!acc && n < 100) begin
            #1;
            acc = bus.in_ready;
            @(negedge clk);
            n++;
        end
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL byte_accept_timeout observed=%0d expected=accept", n);
        end
        bus.in_valid = 1'b0;
        sum = sum + b;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        sb_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 1'b1;
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            if (gap) tick();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = '0;
        sum = '0;
    endtask

    task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = ~sum + 8'd1;
        send_byte(c);
`else
        tick();
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        exp_addr     = '0;
        sum          = '0;
        repeat (3) tick();

        // Reset state
        check("rst_cpu_run", 64'(cpu_run), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic two-word image
        do_start();
        send_word(32'h2001_0005, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_image();
        repeat (3) tick();
        check("t1_cpu_run", 64'(cpu_run), 64'd1);
        check("t1_words", 64'(words_loaded), 64'd2);
        check("t1_err", 64'(err), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_sb_empty", 64'(sb_q.size()), 64'd0);
        check("t1_addr_hold", 64'(bus.imem_addr), 64'd1);
        check("t1_data_hold", 64'(bus.imem_wdata), 64'hFFFF_FFFF);
        // Bytes offered in DONE are ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) tick();
        check("done_in_ready", 64'(bus.in_ready), 64'd0);
        check("done_cpu_run", 64'(cpu_run), 64'd1);
        bus.in_valid = 1'b0;

        // Start pulsed in DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = '0;
        sum = '0;
        check("t6_cpu_run", 64'(cpu_run), 64'd0);
        check("t6_busy", 64'(busy), 64'd1);
        check("t6_words", 64'(words_loaded), 64'd0);

        // Second image with in_valid toggling every cycle
        send_word(32'h1122_3344, 1'b1);
        send_word(32'hA5A5_5A5A, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        finish_image();
        repeat (3) tick();
        check("t2_cpu_run", 64'(cpu_run), 64'd1);
        check("t2_words", 64'(words_loaded), 64'd3);
        check("t2_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset after 6 bytes of a load
        do_start();
        send_word(32'h0102_0304, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_cpu_run", 64'(cpu_run), 64'd0);
        check("t4_in_ready", 64'(bus.in_ready), 64'd0);
        check("t4_we", 64'(bus.imem_we), 64'd0);
        check("t4_words", 64'(words_loaded), 64'd0);
        check("t4_addr", 64'(bus.imem_addr), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("t4_sb_empty", 64'(sb_q.size()), 64'd0);
        do_start();
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_image();
        repeat (3) tick();
        check("t4_reload_run", 64'(cpu_run), 64'd1);
        check("t4_reload_sb", 64'(sb_q.size()), 64'd0);

        // Capacity overflow: DEPTH words without a halt word
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'(i) + 32'h1000_0000, 1'b0);
        end
        repeat (3) tick();
        check("t3_err", 64'(err), 64'd1);
        check("t3_cpu_run", 64'(cpu_run), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_words", 64'(words_loaded), 64'(DEPTH));
        check("t3_sb_empty", 64'(sb_q.size()), 64'd0);
        check("t3_last_addr", 64'(bus.imem_addr), 64'(DEPTH - 1));
        do_start();
        check("t3_err_clear", 64'(err), 64'd0);
        check("t3_busy_again", 64'(busy), 64'd1);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_image();
        repeat (3) tick();
        check("t3_recover_run", 64'(cpu_run), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum pass and fail
        do_start();
        send_word(32'h2001_0005, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        send_byte(~sum + 8'd1);
        repeat (2) tick();
        check("t5_pass_run", 64'(cpu_run), 64'd1);
        check("t5_pass_err", 64'(err), 64'd0);
        do_start();
        send_word(32'h2001_0005, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        send_byte(~sum + 8'd2);
        repeat (2) tick();
        check("t5_fail_err", 64'(err), 64'd1);
        check("t5_fail_run", 64'(cpu_run), 64'd0);
`endif

        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
